// File: rtl/bulk_in_buffer_filler_pkg.sv
// Shared types and constants for the FX3 bulk-in buffer filler.
package fx3_bulk_pkg;

   localparam int unsigned SAMPLE_W      = 16;
   localparam int unsigned WORD_W        = 2 * SAMPLE_W;

   // Header word layout: {tag, buf_seq, frame_seq}
   localparam int unsigned HDR_TAG_W     = 8;
   localparam int unsigned HDR_BSEQ_W    = 8;
   localparam int unsigned HDR_FSEQ_W    = 16;

   localparam int unsigned BUF_DEPTH_MIN = 7;
   localparam int unsigned BUF_DEPTH_MAX = 18;

   localparam logic [HDR_TAG_W-1:0] HDR_MAGIC_DEF = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_FILL = 3'd2,
      S_PAD  = 3'd3,
      S_HOLD = 3'd4
   } fill_state_t;

endpackage

// File: rtl/bulk_in_buffer_filler_if.sv
// Sample stream, FIFO write port and FX3 handshake bundle.
interface bulk_in_buffer_filler_if;
   import fx3_bulk_pkg::*;

   logic                bulkInStart;
   logic [SAMPLE_W-1:0] pix_data;
   logic                pix_vld;
   logic                pix_last;
   logic                pix_ready;
   logic                currentXferDone;
   logic                wr_enable;
   logic [WORD_W-1:0]   wr_data;
   logic                xfer_ready;
   logic                proto_err;

   // Filler side
   modport master (
      input  bulkInStart, pix_data, pix_vld, pix_last, currentXferDone,
      output pix_ready, wr_enable, wr_data, xfer_ready, proto_err
   );

   // Source / FIFO / FX3 side
   modport slave (
      output bulkInStart, pix_data, pix_vld, pix_last, currentXferDone,
      input  pix_ready, wr_enable, wr_data, xfer_ready, proto_err
   );

endinterface

// File: rtl/bulk_in_buffer_filler_packer.sv
// Packs two 16-bit samples into one 32-bit word; flushes a lone half on frame end.
module bulk_word_packer
   import fx3_bulk_pkg::*;
(
   input  logic                sys_clk,
   input  logic                clr,
   input  logic                accept,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                last,
   output logic                word_done_c,
   output logic [WORD_W-1:0]   word_c
);

   logic [SAMPLE_W-1:0] half_q;
   logic                half_full_q;

   // A word completes on its second half, or early when the frame ends on a first half
   always_comb begin
      word_done_c = accept & (half_full_q | last);
      word_c      = half_full_q ? {sample, half_q} : {SAMPLE_W'(0), sample};
   end

   // Low-half holding register
   always_ff @(posedge sys_clk) begin
      if (clr) begin
         half_q      <= '0;
         half_full_q <= 1'b0;
      end else if (accept) begin
         if (half_full_q | last) begin
            half_full_q <= 1'b0;
         end else begin
            half_q      <= sample;
            half_full_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bulk_in_buffer_filler.sv
// Builds one FX3 bulk-in buffer: header, packed payload, zero pad, then holds for transfer.
module bulk_in_buffer_filler
   import fx3_bulk_pkg::*;
#(
   parameter int unsigned            BUF_DEPTH = 16,
   parameter logic [HDR_TAG_W-1:0]   HDR_MAGIC = HDR_MAGIC_DEF
)(
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     frame_rst,
   bulk_in_buffer_filler_if.master  bus
);

   if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
      $error("bulk_in_buffer_filler: BUF_DEPTH out of range");
   end

   // Last payload index: payload words plus the header fill 2**BUF_DEPTH words
   localparam logic [BUF_DEPTH-1:0] P_LAST = '1;

   fill_state_t             state, state_n;
   logic [BUF_DEPTH-1:0]    wcnt, wcnt_n, wcnt_inc;
   logic [HDR_BSEQ_W-1:0]   buf_seq, buf_seq_n;
   logic [HDR_FSEQ_W-1:0]   frame_seq, frame_seq_n;
   logic                    last_seen, last_seen_n;
   logic                    proto_err_q, proto_err_n;
   logic                    wr_en_q, wr_en_n;
   logic [WORD_W-1:0]       wr_data_q, wr_data_n;
   logic                    xfer_ready_q;
   logic                    clr;
   logic                    accept;
   logic                    word_done_c;
   logic [WORD_W-1:0]       word_c;

   assign clr      = sys_rst | frame_rst;
   assign accept   = (state == S_FILL) & bus.pix_vld;
   assign wcnt_inc = wcnt + BUF_DEPTH'(1);

   assign bus.pix_ready  = (state == S_FILL);
   assign bus.wr_enable  = wr_en_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.xfer_ready = xfer_ready_q;
   assign bus.proto_err  = proto_err_q;

   bulk_word_packer u_packer (
      .sys_clk     (sys_clk),
      .clr         (clr),
      .accept      (accept),
      .sample      (bus.pix_data),
      .last        (bus.pix_last),
      .word_done_c (word_done_c),
      .word_c      (word_c)
   );

   // Next-state, counters, sequence numbers and the next FIFO write
   always_comb begin
      state_n     = state;
      wcnt_n      = wcnt;
      buf_seq_n   = buf_seq;
      frame_seq_n = frame_seq;
      last_seen_n = last_seen;
      wr_en_n     = 1'b0;
      wr_data_n   = '0;
      proto_err_n = proto_err_q | (bus.currentXferDone & (state != S_HOLD));

      case (state)
         S_IDLE: begin
            if (bus.bulkInStart) state_n = S_HDR;
         end
         S_HDR: begin
            wr_en_n   = 1'b1;
            wr_data_n = {HDR_MAGIC, buf_seq, frame_seq};
            wcnt_n    = '0;
            state_n   = S_FILL;
         end
         S_FILL: begin
            if (word_done_c) begin
               wr_en_n   = 1'b1;
               wr_data_n = word_c;
               wcnt_n    = wcnt_inc;
               if (wcnt_inc == P_LAST) state_n = S_HOLD;
            end
            if (accept & bus.pix_last) begin
               last_seen_n = 1'b1;
               frame_seq_n = frame_seq + HDR_FSEQ_W'(1);
               if (wcnt_inc != P_LAST) state_n = S_PAD;
            end
         end
         S_PAD: begin
            wr_en_n = 1'b1;
            wcnt_n  = wcnt_inc;
            if (wcnt_inc == P_LAST) state_n = S_HOLD;
         end
         S_HOLD: begin
            if (bus.currentXferDone) begin
               buf_seq_n = buf_seq + HDR_BSEQ_W'(1);
               if (last_seen) begin
                  last_seen_n = 1'b0;
                  state_n     = S_IDLE;
               end else begin
                  state_n = S_HDR;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and output registers; either reset source returns everything to idle
   always_ff @(posedge sys_clk) begin
      if (clr) begin
         state        <= S_IDLE;
         wcnt         <= '0;
         buf_seq      <= '0;
         frame_seq    <= '0;
         last_seen    <= 1'b0;
         proto_err_q  <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         xfer_ready_q <= 1'b0;
      end else begin
         state        <= state_n;
         wcnt         <= wcnt_n;
         buf_seq      <= buf_seq_n;
         frame_seq    <= frame_seq_n;
         last_seen    <= last_seen_n;
         proto_err_q  <= proto_err_n;
         wr_en_q      <= wr_en_n;
         wr_data_q    <= wr_data_n;
         xfer_ready_q <= (state == S_HOLD) & ~bus.currentXferDone;
      end
   end

endmodule
